// File: rtl/sdram_arb_pkg.sv
// Shared types and default widths for the SDRAM master-port arbiter.
// Imported by the interface-facing top and the round-robin picker.
package sdram_arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } arb_state_e;

  localparam int DEF_N        = 2;
  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_LOCK_MAX = 8;
  localparam int GRANT_W      = 2;
  localparam int LOCK_CNT_W   = 8;

endpackage

// File: rtl/sdram_master_arbiter_if.sv
// Requester-side and SDRAM-side Avalon-MM signals of the arbiter.
// Requester buses are flattened: slice i belongs to requester i.
interface sdram_master_arbiter_if #(
  parameter int N      = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [N*ADDR_W-1:0] req_address;
  logic [N-1:0]        req_read;
  logic [N-1:0]        req_write;
  logic [N*DATA_W-1:0] req_writedata;
  logic [N-1:0]        req_lock;
  logic [N-1:0]        req_waitrequest;
  logic [DATA_W-1:0]   req_readdata;

  logic                master_waitrequest;
  logic [ADDR_W-1:0]   master_address;
  logic                master_read;
  logic                master_write;
  logic [DATA_W-1:0]   master_writedata;
  logic [DATA_W-1:0]   master_readdata;

  // Arbiter view: accepts requester commands, drives the SDRAM port.
  modport slave (
    input  req_address, req_read, req_write, req_writedata, req_lock,
    output req_waitrequest, req_readdata,
    input  master_waitrequest, master_readdata,
    output master_address, master_read, master_write, master_writedata
  );

  // Environment view: requesters plus the SDRAM controller.
  modport master (
    output req_address, req_read, req_write, req_writedata, req_lock,
    input  req_waitrequest, req_readdata,
    output master_waitrequest, master_readdata,
    input  master_address, master_read, master_write, master_writedata
  );

endinterface

// File: rtl/sdram_master_arbiter_rr_picker.sv
// Combinational N-way round-robin priority encoder: the search starts at
// last_grant+1 and wraps, so the previous grantee has lowest priority.
module rr_picker #(
  parameter int N = 2
) (
  input  logic [N-1:0] pending,
  input  logic [1:0]   last_grant,
  output logic [1:0]   winner,
  output logic         any
);

  localparam int IDX_W = (N > 2) ? 2 : 1;

  logic [IDX_W-1:0] idx_s;
  logic             found_s;

  // First pending requester after last_grant, modulo N.
  always_comb begin
    winner  = 2'd0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int k = 1; k <= N; k++) begin
      idx_s = IDX_W'((int'(last_grant) + k) % N);
      if (!found_s && pending[idx_s]) begin
        winner  = 2'(idx_s);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign any = |pending;

endmodule

// File: rtl/sdram_master_arbiter.sv
// Round-robin arbiter sharing one SDRAM Avalon-MM master between N
// requesters, with lock windows bounded by LOCK_MAX completed transfers.
module sdram_master_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int LOCK_MAX = DEF_LOCK_MAX
) (
  input  logic                 clk,
  input  logic                 reset,
  sdram_master_arbiter_if.slave bus,
  output logic                 grant_valid,
  output logic [GRANT_W-1:0]   grant_idx
);

  localparam int IDX_W = (N > 2) ? 2 : 1;

  arb_state_e              state_q, state_d;
  logic [GRANT_W-1:0]      grant_idx_q, grant_idx_d;
  logic [GRANT_W-1:0]      last_grant_q, last_grant_d;
  logic [LOCK_CNT_W-1:0]   lock_cnt_q, lock_cnt_d;

  logic [N-1:0]            pending_s;
  logic [GRANT_W-1:0]      winner_s;
  logic                    any_s;
  logic [IDX_W-1:0]        g_s;
  logic [LOCK_CNT_W:0]     lock_inc_s;
  logic                    done_s;

  logic [ADDR_W-1:0]       m_address_s;
  logic                    m_read_s;
  logic                    m_write_s;
  logic [DATA_W-1:0]       m_writedata_s;
  logic [N-1:0]            r_wait_s;
  logic [DATA_W-1:0]       r_readdata_s;

  assign pending_s  = bus.req_read | bus.req_write;
  assign g_s        = grant_idx_q[IDX_W-1:0];
  assign lock_inc_s = {1'b0, lock_cnt_q} + 9'd1;
  assign done_s     = pending_s[g_s] & ~bus.master_waitrequest;

  rr_picker #(.N(N)) u_picker (
    .pending    (pending_s),
    .last_grant (last_grant_q),
    .winner     (winner_s),
    .any        (any_s)
  );

  // State and grant bookkeeping registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_idx_q  <= 2'd0;
      last_grant_q <= GRANT_W'(N - 1);
      lock_cnt_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      grant_idx_q  <= grant_idx_d;
      last_grant_q <= last_grant_d;
      lock_cnt_q   <= lock_cnt_d;
    end
  end

  // Next-state: grant on any pending, release on unlocked completion or limit.
  always_comb begin
    state_d      = state_q;
    grant_idx_d  = grant_idx_q;
    last_grant_d = last_grant_q;
    lock_cnt_d   = lock_cnt_q;
    case (state_q)
      IDLE: begin
        if (any_s) begin
          state_d     = GRANTED;
          grant_idx_d = winner_s;
          lock_cnt_d  = 8'd0;
        end else begin
          state_d = IDLE;
        end
      end
      GRANTED: begin
        if (done_s) begin
          last_grant_d = grant_idx_q;
          if (bus.req_lock[g_s] && (lock_inc_s < 9'(LOCK_MAX))) begin
            lock_cnt_d = lock_inc_s[LOCK_CNT_W-1:0];
          end else begin
            state_d    = IDLE;
            lock_cnt_d = 8'd0;
          end
        end else if (!pending_s[g_s] && !bus.req_lock[g_s]) begin
          // Grantee walked away without a lock: free the port, keep rotation.
          state_d    = IDLE;
          lock_cnt_d = 8'd0;
        end else begin
          state_d = GRANTED;
        end
      end
      default: begin
        state_d    = IDLE;
        lock_cnt_d = 8'd0;
      end
    endcase
  end

  // Datapath mux: only the grantee reaches the SDRAM port; read wins a clash.
  always_comb begin
    m_address_s   = '0;
    m_read_s      = 1'b0;
    m_write_s     = 1'b0;
    m_writedata_s = '0;
    r_wait_s      = '1;
    r_readdata_s  = '0;
    if (state_q == GRANTED) begin
      m_address_s   = bus.req_address[int'(g_s)*ADDR_W +: ADDR_W];
      m_writedata_s = bus.req_writedata[int'(g_s)*DATA_W +: DATA_W];
      if (bus.req_read[g_s]) begin
        m_read_s = 1'b1;
      end else if (bus.req_write[g_s]) begin
        m_write_s = 1'b1;
      end else begin
        m_read_s = 1'b0;
      end
      r_wait_s[g_s] = bus.master_waitrequest;
      r_readdata_s  = bus.master_readdata;
    end else begin
      r_wait_s = '1;
    end
  end

  assign bus.master_address   = m_address_s;
  assign bus.master_read      = m_read_s;
  assign bus.master_write     = m_write_s;
  assign bus.master_writedata = m_writedata_s;
  assign bus.req_waitrequest  = r_wait_s;
  assign bus.req_readdata     = r_readdata_s;

  assign grant_valid = (state_q == GRANTED);
  assign grant_idx   = grant_idx_q;

endmodule

// File: doc/sdram_master_arbiter.md
Name: sdram_master_arbiter

Overview:
Round-robin arbiter that shares the single SDRAM-facing Avalon-MM master port between N accelerator controllers (max-pool, conv, DMA). Each accelerator sees a private master interface with waitrequest back-pressure. The arbiter forwards one requester's command at a time and supports a lock input for multi-transfer windows, e.g. a 2x2 pooling window read. Lock ownership is bounded by a fairness counter.

Parameters:
N, 2, number of requesters (2..4)
ADDR_W, 32, address width
DATA_W, 32, data width
LOCK_MAX, 8, max completed transfers per locked grant before forced release (1..255)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low
req_address  in  N*ADDR_W  per-requester byte address, slice i = requester i
req_read  in  N  per-requester read strobe
req_write  in  N  per-requester write strobe
req_writedata  in  N*DATA_W  per-requester write data
req_lock  in  N  hold grant after current transfer
req_waitrequest  out  N  per-requester stall
req_readdata  out  DATA_W  shared read data, valid for grantee only
master_waitrequest  in  1  SDRAM stall
master_address  out  ADDR_W  SDRAM address
master_read  out  1  SDRAM read
master_write  out  1  SDRAM write
master_writedata  out  DATA_W  SDRAM write data
master_readdata  in  DATA_W  SDRAM read data
grant_valid  out  1  a requester holds the port
grant_idx  out  2  index of current grantee

Behaviour:
- Reset (async, active-low), effective immediately including mid-transfer:
  - state=IDLE; grant_valid=0; grant_idx=0; last_grant=N-1; lock_cnt=0.
  - req_waitrequest all 1; master_read=0; master_write=0; master_address=0; master_writedata=0.
- Pending for requester i = req_read[i] | req_write[i].
- States: IDLE, GRANTED.
- IDLE:
  - All req_waitrequest=1; master outputs zero.
  - If any pending: winner = first pending index searching last_grant+1, +2, ... modulo N. Next edge: grant_idx<=winner, grant_valid<=1, lock_cnt<=0, state<=GRANTED.
  - Minimum latency from request to first downstream command: 1 cycle.
- GRANTED, grantee g:
  - master_* driven combinationally from slice g.
  - If req_read[g] & req_write[g] both high: master_read=1, master_write=0 (illegal; read wins).
  - req_waitrequest[g] = master_waitrequest. All other req_waitrequest=1.
  - req_readdata = master_readdata.
- Completion: pending[g] & !master_waitrequest at a clock edge. At completion:
  - last_grant<=g.
  - If req_lock[g] & (lock_cnt+1 < LOCK_MAX): stay GRANTED, lock_cnt<=lock_cnt+1.
  - Else: state<=IDLE, grant_valid<=0, lock_cnt<=0.
- Forced release: when the limit is hit, the next arbitration excludes nobody but starts after g. g regains the port only if no other requester is pending.
- GRANTED with !pending[g] and !req_lock[g]: release to IDLE without updating last_grant.
- GRANTED with !pending[g] and req_lock[g]: hold grant; master_read=master_write=0.
- Downstream stall: while master_waitrequest=1, all master outputs stay stable. Requesters must hold their command (Avalon rule).
- lock_cnt is 8 bits and never wraps; bounded by LOCK_MAX.
- Read data is combinational pass-through. No readdatavalid and no pipelining: one outstanding transfer.

Decomposition:
- Package sdram_arb_pkg: state encoding (IDLE=1'b0, GRANTED=1'b1); default widths.
- Sub-module rr_picker: combinational N-way round-robin priority encoder. Inputs pending[N] and last_grant; outputs winner and any.

Test Plan:
- Single read: req_read[0]=1, addr 0x100 at cycle T, master_waitrequest=0, master_readdata=0xDEADBEEF -> at T+1 master_read=1, master_address=0x100, req_waitrequest[0]=0, req_readdata=0xDEADBEEF; grant_valid=0 at T+2.
- Contention: req0 and req1 each issue 2 writes from reset (0xA0/0xB0), no locks -> downstream order req0, req1, req0, req1; last_grant toggles each transfer.
- Lock window: req1 lock=1 with 4 consecutive reads 0x10/0x14/0x50/0x54 while req0 pending -> 4 back-to-back req1 transfers with no IDLE cycle, then req0 granted.
- Lock fairness: LOCK_MAX=8, req0 locked and continuously reading, req1 pending -> after the 8th req0 completion, IDLE, then req1 granted; req0 stalled meanwhile.
- Stall: master_waitrequest=1 for 5 cycles during req1 write of data 0x12345678 -> master outputs stable, req_waitrequest[1]=1 for 5 cycles, completes on the 6th.
- Reset mid-transfer: reset low while GRANTED and stalled -> same cycle master_read/write=0, all req_waitrequest=1, grant_valid=0. After release, first arbitration starts at requester 0.
